// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- ALU with valid/ready handshakes on both sides and registered
// results. Most operations finish one cycle after they are accepted. An
// optional iterative multiplier handles opcode 1100 and is included only when
// the macro ALU_SEQ_MUL_EN is defined. Without that macro, 1100 is treated as
// an undefined code.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    request present          in_ready    request accepted this cycle
//   in_alu_1    operand A                in_alu_2    operand B / shift amount
//   alu_ctrl    4-bit opcode
//   out_valid   result registers valid   out_ready   consumer takes result
//   alu_result  registered result        zero        registered zero/equal flag
//   overflow    signed ADD/SUB overflow  err         undefined opcode flag
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_alu_1,
  input  logic [WIDTH-1:0] in_alu_2,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1100;
`endif

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_err;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_ovf;
  logic             w_err;
  logic             w_is_mul;
  logic             w_accept;

  assign w_sum    = in_alu_1 + in_alu_2;
  assign w_diff   = in_alu_1 - in_alu_2;
  assign w_shamt  = in_alu_2[SHW-1:0];
  assign w_accept = in_valid && in_ready;

  // Combinational evaluation of single-cycle opcodes. These values are
  // captured only on an accept cycle.
  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    w_err    = 1'b0;
    w_is_mul = 1'b0;
    case (alu_ctrl)
      OP_AND:  w_result = in_alu_1 & in_alu_2;
      OP_OR:   w_result = in_alu_1 | in_alu_2;
      OP_ADD: begin
        w_result = w_sum;
        // Two operands with the same sign produced a result of the other sign.
        w_ovf = (in_alu_1[WIDTH-1] == in_alu_2[WIDTH-1]) &&
                (w_sum[WIDTH-1] != in_alu_1[WIDTH-1]);
      end
      OP_SUB: begin
        w_result = w_diff;
        w_ovf = (in_alu_1[WIDTH-1] != in_alu_2[WIDTH-1]) &&
                (w_diff[WIDTH-1] != in_alu_1[WIDTH-1]);
      end
      OP_BEQ:  w_result = '0;
      OP_NOR:  w_result = ~(in_alu_1 | in_alu_2);
      OP_XOR:  w_result = in_alu_1 ^ in_alu_2;
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(in_alu_1) < $signed(in_alu_2))};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (in_alu_1 < in_alu_2)};
      OP_SLL:  w_result = in_alu_1 << w_shamt;
      OP_SRL:  w_result = in_alu_1 >> w_shamt;
      OP_SRA:  w_result = WIDTH'($signed(in_alu_1) >>> w_shamt);
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  w_is_mul = 1'b1;
`endif
      default: w_err = 1'b1;
    endcase
  end

  // BEQ reports equality of the operands. Undefined codes always report
  // zero = 0, even though their result is 0.
  always_comb begin
    w_zero = 1'b0;
    if (alu_ctrl == OP_BEQ) begin
      w_zero = (in_alu_1 == in_alu_2);
    end else if (!w_err) begin
      w_zero = (w_result == '0);
    end
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = SHW + 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic             w_mul_done;

  // WIDTH shift-add iterations run on the edges after the accept. The result
  // is loaded on the following edge, so out_valid rises WIDTH+1 cycles after
  // the accept.
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == CW'(WIDTH));
  assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
      S_MUL:   if (w_mul_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= '0;
      r_mcand  <= in_alu_1;
      r_mplier <= in_alu_2;
      r_acc    <= '0;
    end else if (w_mul_done) begin
      r_cnt <= '0;
    end else if (r_state == S_MUL) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign in_ready = !r_out_valid || out_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_result;
      r_zero      <= w_zero;
      r_ovf       <= w_ovf;
      r_err       <= w_err;
`ifdef ALU_SEQ_MUL_EN
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= r_acc;
      r_zero      <= (r_acc == '0);
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign zero       = r_zero;
  assign overflow   = r_ovf;
  assign err        = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- scoreboard bench for alu_seq (WIDTH = 32). The driver pushes
// hand-computed expectations when a request is accepted. The monitor compares
// each presented result against the head of the queue. During a stall it
// compares without popping. When out_ready is high it pops the entry.
// MUL checks are compiled in only when ALU_SEQ_MUL_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_alu_1 = '0;
  logic [W-1:0] in_alu_2 = '0;
  logic [3:0]   alu_ctrl = 4'h0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_result;
  logic         zero;
  logic         overflow;
  logic         err;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_1(in_alu_1), .in_alu_2(in_alu_2), .alu_ctrl(alu_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .zero(zero), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         o;
    logic         e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, wanted no output", alu_result);
      end else begin
        chk($sformatf("result[%0d]", n_pop), {32'h0, alu_result}, {32'h0, sb[0].r});
        chk($sformatf("zero[%0d]", n_pop), {63'h0, zero}, {63'h0, sb[0].z});
        chk($sformatf("overflow[%0d]", n_pop), {63'h0, overflow}, {63'h0, sb[0].o});
        chk($sformatf("err[%0d]", n_pop), {63'h0, err}, {63'h0, sb[0].e});
        if (out_ready) begin
          $display("txn %0d: result=0x%08h zero=%b ovf=%b err=%b", n_pop, alu_result, zero, overflow, err);
          void'(sb.pop_front());
          n_pop++;
        end
      end
    end
  end

  // Driver: holds the request until in_ready is seen, within a cycle budget.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] r, input logic z, input logic o, input logic e);
    int cyc = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    alu_ctrl = op;
    in_alu_1 = a;
    in_alu_2 = b;
    while (!acc && cyc < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (acc) begin
      sb.push_back('{r: r, z: z, o: o, e: e});
      n_push++;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, wanted accept op=%h", op);
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_result", {32'h0, alu_result}, 64'h0);
    chk("rst_flags", {61'h0, zero, overflow, err}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    @(posedge clk);
    #1;

    // ADD with latency check
    send(4'b0010, 32'h0000000E, 32'h00000019, 32'h00000027, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_latency_valid", {63'h0, out_valid}, 64'h1);
    @(posedge clk);
    #1;

    // Back-to-back directed vectors
    send(4'b0011, 32'h8, 32'hA, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    send(4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0);
    send(4'b0011, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    send(4'b0010, 32'hFFFFFFFF, 32'h1, 32'h00000000, 1'b1, 1'b0, 1'b0);
    send(4'b0100, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);
    send(4'b0100, 32'h4, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0);
    send(4'b1011, 32'h80000000, 32'h24, 32'hF8000000, 1'b0, 1'b0, 1'b0);
    send(4'b1010, 32'h80000000, 32'h24, 32'h08000000, 1'b0, 1'b0, 1'b0);
    send(4'b1001, 32'h1, 32'h21, 32'h2, 1'b0, 1'b0, 1'b0);
    send(4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
    send(4'b1000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0);
    send(4'b0110, 32'hF0, 32'hFF, 32'h0F, 1'b0, 1'b0, 1'b0);
    send(4'b0000, 32'hF0, 32'h0F, 32'h0, 1'b1, 1'b0, 1'b0);
    send(4'b1111, 32'h3, 32'h3, 32'h0, 1'b0, 1'b0, 1'b1);

    // Stall: AND accepted, out_ready low for one cycle, then OR and NOR
    send(4'b0000, 32'hF, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0001;
    in_alu_1  = 32'h8;
    in_alu_2  = 32'h4;
    @(negedge clk);
    chk("stall_in_ready", {63'h0, in_ready}, 64'h0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(4'b0001, 32'h8, 32'h4, 32'hC, 1'b0, 1'b0, 1'b0);
    send(4'b0101, 32'h1, 32'h4, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SEQ_MUL_EN
    repeat (2) @(posedge clk);
    #1;
    send(4'b1100, 32'h1234, 32'h10, 32'h00012340, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_ready[%0d]", k), {63'h0, in_ready}, 64'h0);
      chk($sformatf("mul_busy_valid[%0d]", k), {63'h0, out_valid}, 64'h0);
    end
    @(negedge clk);
    chk("mul_done_valid", {63'h0, out_valid}, 64'h1);
    @(posedge clk);
    #1;

    // Reset during multiply abandons it
    send(4'b1100, 32'h1234, 32'h10, 32'h00012340, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    n_push--;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mul_rst_in_ready", {63'h0, in_ready}, 64'h1);
    for (int k = 0; k < W + 5; k++) begin
      @(negedge clk);
      chk($sformatf("mul_rst_no_valid[%0d]", k), {63'h0, out_valid}, 64'h0);
    end
`else
    send(4'b1100, 32'h1234, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("mul_undef_latency", {63'h0, out_valid}, 64'h1);
    @(posedge clk);
    #1;
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    chk("txn_count", 64'(n_pop), 64'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
